// File: rtl/win_banner_pkg.sv
// Shared types and default geometry for the "YOU WIN" banner controller.
package win_banner_pkg;

    localparam int unsigned COORD_W  = 11;
    localparam int unsigned BANNER_W = 80;
    localparam int unsigned BANNER_H = 20;
    localparam int unsigned BANNER_X = 280;
    localparam int unsigned BANNER_Y = 230;

    typedef enum logic [1:0] {
        StIdle,
        StSlide,
        StBlink,
        StHold
    } banner_state_e;

endpackage

// File: rtl/banner_rect_hit.sv
// Registered rectangle hit test: one-cycle latency from pixel position to inside/offset outputs.
module banner_rect_hit
    import win_banner_pkg::*;
#(
    parameter int unsigned WIDTH  = BANNER_W,
    parameter int unsigned HEIGHT = BANNER_H
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [COORD_W-1:0] i_pixel_x,
    input  logic [COORD_W-1:0] i_pixel_y,
    input  logic [COORD_W-1:0] i_top_left_x,
    input  logic [COORD_W-1:0] i_top_left_y,
    output logic               o_inside,
    output logic [COORD_W-1:0] o_offset_x,
    output logic [COORD_W-1:0] o_offset_y
);

    logic [COORD_W:0] w_dx;
    logic [COORD_W:0] w_dy;
    logic             w_inside;

    // One extra bit so a pixel left of / above the box shows up as negative.
    assign w_dx = {1'b0, i_pixel_x} - {1'b0, i_top_left_x};
    assign w_dy = {1'b0, i_pixel_y} - {1'b0, i_top_left_y};

    assign w_inside = !w_dx[COORD_W] && (w_dx[COORD_W-1:0] < COORD_W'(WIDTH)) &&
                      !w_dy[COORD_W] && (w_dy[COORD_W-1:0] < COORD_W'(HEIGHT));

    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_inside   <= 1'b0;
            o_offset_x <= '0;
            o_offset_y <= '0;
        end else begin
            o_inside   <= w_inside;
            o_offset_x <= w_inside ? w_dx[COORD_W-1:0] : '0;
            o_offset_y <= w_inside ? w_dy[COORD_W-1:0] : '0;
        end
    end

endmodule

// File: rtl/win_banner_ctrl.sv
// Slide/blink/hold animation controller for the win banner bitmap stage.
// Optional slide-in animation is enabled with `define WIN_BANNER_SLIDE_EN.
module win_banner_ctrl
    import win_banner_pkg::*;
#(
    parameter int unsigned OBJECT_WIDTH_X = BANNER_W,
    parameter int unsigned OBJECT_HEIGHT_Y = BANNER_H,
    parameter int unsigned TARGET_X = BANNER_X,
    parameter int unsigned TARGET_Y = BANNER_Y,
    parameter int unsigned START_Y = 0,
    parameter int unsigned SLIDE_STEP = 4,
    parameter int unsigned BLINK_FRAMES = 15,
    parameter int unsigned BLINK_TOGGLES = 6
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic [COORD_W-1:0] pixelX,
    input  logic [COORD_W-1:0] pixelY,
    input  logic               startOfFrame,
    input  logic               gameWon,
    input  logic               gameRestart,
    output logic [COORD_W-1:0] offsetX,
    output logic [COORD_W-1:0] offsetY,
    output logic               InsideRectangle,
    output logic               draw,
    output logic               bannerActive
);

    localparam int unsigned FRAME_W  = $clog2(BLINK_FRAMES + 1);
    localparam int unsigned TOGGLE_W = $clog2(BLINK_TOGGLES + 1);
    localparam logic [COORD_W-1:0] TARGET_Y_C = COORD_W'(TARGET_Y);
    localparam logic [COORD_W-1:0] START_Y_C  = COORD_W'(START_Y);

    banner_state_e       r_state, w_state_d;
    logic [COORD_W-1:0]  r_top_y, w_top_y_d;
    logic [FRAME_W-1:0]  r_frame_cnt, w_frame_d;
    logic [TOGGLE_W-1:0] r_toggle_cnt, w_toggle_d;
    logic                r_draw, w_draw_d;
    logic [TOGGLE_W-1:0] w_toggle_inc;

    assign w_toggle_inc = r_toggle_cnt + TOGGLE_W'(1);

`ifdef WIN_BANNER_SLIDE_EN
    logic [COORD_W:0]   w_slide_sum;
    logic [COORD_W-1:0] w_slide_y;

    // Clamp also covers START_Y >= TARGET_Y: the first frame lands on TARGET_Y.
    assign w_slide_sum = {1'b0, r_top_y} + (COORD_W+1)'(SLIDE_STEP);
    assign w_slide_y   = (w_slide_sum >= {1'b0, TARGET_Y_C}) ? TARGET_Y_C
                                                             : w_slide_sum[COORD_W-1:0];
`else
    logic w_unused_slide_step;
    assign w_unused_slide_step = ^SLIDE_STEP;
`endif

    always_ff @(posedge clk) begin
        if (resetN) begin
            r_state      <= StIdle;
            r_top_y      <= START_Y_C;
            r_frame_cnt  <= '0;
            r_toggle_cnt <= '0;
            r_draw       <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_top_y      <= w_top_y_d;
            r_frame_cnt  <= w_frame_d;
            r_toggle_cnt <= w_toggle_d;
            r_draw       <= w_draw_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_top_y_d  = r_top_y;
        w_frame_d  = r_frame_cnt;
        w_toggle_d = r_toggle_cnt;
        w_draw_d   = r_draw;
        if (gameRestart) begin
            w_state_d  = StIdle;
            w_top_y_d  = START_Y_C;
            w_frame_d  = '0;
            w_toggle_d = '0;
            w_draw_d   = 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    w_draw_d = 1'b0;
                    if (gameWon) begin
                        w_draw_d   = 1'b1;
                        w_frame_d  = '0;
                        w_toggle_d = '0;
`ifdef WIN_BANNER_SLIDE_EN
                        w_top_y_d  = START_Y_C;
                        w_state_d  = StSlide;
`else
                        w_top_y_d  = TARGET_Y_C;
                        w_state_d  = StBlink;
`endif
                    end
                end
`ifdef WIN_BANNER_SLIDE_EN
                StSlide: begin
                    w_draw_d = 1'b1;
                    if (startOfFrame) begin
                        w_top_y_d = w_slide_y;
                        if (w_slide_y == TARGET_Y_C) begin
                            w_state_d  = StBlink;
                            w_frame_d  = '0;
                            w_toggle_d = '0;
                        end
                    end
                end
`endif
                StBlink: begin
                    if (startOfFrame) begin
                        if (r_frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
                            w_frame_d  = '0;
                            w_draw_d   = ~r_draw;
                            w_toggle_d = w_toggle_inc;
                            if (w_toggle_inc == TOGGLE_W'(BLINK_TOGGLES)) begin
                                w_state_d = StHold;
                                w_draw_d  = 1'b1;
                            end
                        end else begin
                            w_frame_d = r_frame_cnt + FRAME_W'(1);
                        end
                    end
                end
                StHold: begin
                    w_draw_d  = 1'b1;
                    w_top_y_d = TARGET_Y_C;
                end
                default: begin
                    w_state_d = StIdle;
                    w_draw_d  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        draw         = r_draw;
        bannerActive = (r_state != StIdle);
    end

    banner_rect_hit #(
        .WIDTH  (OBJECT_WIDTH_X),
        .HEIGHT (OBJECT_HEIGHT_Y)
    ) u_hit (
        .clk          (clk),
        .i_rst        (resetN),
        .i_pixel_x    (pixelX),
        .i_pixel_y    (pixelY),
        .i_top_left_x (COORD_W'(TARGET_X)),
        .i_top_left_y (r_top_y),
        .o_inside     (InsideRectangle),
        .o_offset_x   (offsetX),
        .o_offset_y   (offsetY)
    );

endmodule

// File: tb/tb_win_banner_ctrl.sv
// Directed scoreboard bench for win_banner_ctrl; follows WIN_BANNER_SLIDE_EN like the DUT.
module tb_win_banner_ctrl;

    localparam int BF = 15;
    localparam int BT = 6;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        startOfFrame = 1'b0;
    logic        gameWon = 1'b0;
    logic        gameRestart = 1'b0;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;
    logic        draw;
    logic        bannerActive;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        d;
        logic        a;
        logic        i;
        logic [10:0] ox;
        logic [10:0] oy;
    } exp_t;

    exp_t sb[$];

    win_banner_ctrl dut (
        .clk             (clk),
        .resetN          (resetN),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .startOfFrame    (startOfFrame),
        .gameWon         (gameWon),
        .gameRestart     (gameRestart),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .InsideRectangle (InsideRectangle),
        .draw            (draw),
        .bannerActive    (bannerActive)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of inputs, queue what must appear after the edge, then compare.
    task automatic step(input string tag, input logic rst, input logic sof, input logic won,
                        input logic rs, input int px, input int py, input logic ed,
                        input logic ea, input logic ei, input int eox, input int eoy);
        exp_t e;
        resetN       = rst;
        startOfFrame = sof;
        gameWon      = won;
        gameRestart  = rs;
        pixelX       = 11'(px);
        pixelY       = 11'(py);
        sb.push_back('{tag, ed, ea, ei, 11'(eox), 11'(eoy)});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, "/draw"}, int'(draw), int'(e.d));
        chk({e.tag, "/active"}, int'(bannerActive), int'(e.a));
        chk({e.tag, "/inside"}, int'(InsideRectangle), int'(e.i));
        chk({e.tag, "/offx"}, int'(offsetX), int'(e.ox));
        chk({e.tag, "/offy"}, int'(offsetY), int'(e.oy));
    endtask

    function automatic logic blink_draw(input int f);
        int t;
        t = f / BF;
        return (t >= BT) ? 1'b1 : ((t % 2) == 0);
    endfunction

    // From IDLE: win pulse, then walk the banner to its rest position at Y=230.
    task automatic enter_win();
        step("win", 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
`ifdef WIN_BANNER_SLIDE_EN
        for (int k = 1; k <= 58; k++) begin
            int y;
            y = (4 * k > 230) ? 230 : 4 * k;
            step("slide_sof", 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
            step("slide_pos", 0, 0, 0, 0, 280, y, 1, 1, 1, 0, 0);
        end
`else
        step("direct_pos", 0, 0, 0, 0, 280, 230, 1, 1, 1, 0, 0);
        step("direct_above", 0, 0, 0, 0, 280, 229, 1, 1, 0, 0, 0);
`endif
    endtask

    initial begin
        @(posedge clk);
        #1;
        step("reset", 1, 0, 0, 0, 280, 230, 0, 0, 0, 0, 0);
        step("reset", 1, 0, 0, 0, 280, 230, 0, 0, 0, 0, 0);
        for (int f = 0; f < 3; f++) begin
            step("idle_sof", 0, 1, 0, 0, 100, 100, 0, 0, 0, 0, 0);
            step("idle", 0, 0, 0, 0, 500, 400, 0, 0, 0, 0, 0);
        end

        enter_win();
        for (int f = 1; f <= BF * BT; f++)
            step("blink", 0, 1, 0, 0, 359, 249, blink_draw(f), 1, 1, 79, 19);
        step("edge_x", 0, 0, 0, 0, 360, 249, 1, 1, 0, 0, 0);
        step("edge_y", 0, 0, 0, 0, 300, 250, 1, 1, 0, 0, 0);
        for (int f = 0; f < 200; f++)
            step("hold", 0, 1, 0, 0, 279 + (f % 2), 230, 1, 1, logic'(f % 2), 0, 0);

        step("won_in_hold", 0, 0, 1, 0, 300, 240, 1, 1, 1, 20, 10);
        for (int f = 0; f < 20; f++)
            step("hold_after_won", 0, 1, 0, 0, 280, 230, 1, 1, 1, 0, 0);

        step("restart", 0, 0, 0, 1, 280, 230, 0, 0, 1, 0, 0);
        step("restart_top", 0, 0, 0, 0, 280, 0, 0, 0, 1, 0, 0);
        step("restart_old", 0, 0, 0, 0, 280, 230, 0, 0, 0, 0, 0);

        step("won_and_restart", 0, 0, 1, 1, 100, 100, 0, 0, 0, 0, 0);
        step("after_conflict", 0, 1, 0, 0, 100, 100, 0, 0, 0, 0, 0);

`ifdef WIN_BANNER_SLIDE_EN
        step("win2", 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        for (int k = 1; k <= 25; k++)
            step("slide2", 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step("restart_mid", 0, 0, 0, 1, 280, 100, 0, 0, 1, 0, 0);
`else
        step("win2", 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        for (int f = 1; f <= 20; f++)
            step("blink2", 0, 1, 0, 0, 0, 0, blink_draw(f), 1, 0, 0, 0);
        step("restart_mid", 0, 0, 0, 1, 280, 230, 0, 0, 1, 0, 0);
`endif
        step("restart_mid_top", 0, 0, 0, 0, 280, 0, 0, 0, 1, 0, 0);
        step("restart_mid_sof", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        enter_win();
        for (int f = 1; f <= 5; f++)
            step("blink3", 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step("reset_mid", 1, 0, 0, 0, 280, 230, 0, 0, 0, 0, 0);
        step("reset_mid_top", 0, 0, 0, 0, 280, 0, 0, 0, 1, 0, 0);
        step("reset_mid_sof", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
